pkt_fifo_drop: RTL and testbench

//   Parametrised store-and-forward packet FIFO with discard and inline dual-port storage (no vendor FIFO IP).

---
 rtl/pkt_fifo_drop_if.sv | 29 ++
 rtl/pkt_fifo_drop.sv | 149 ++++++++++++++
 tb/tb_pkt_fifo_drop.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_fifo_drop_if.sv
// Packet stream bundle for pkt_fifo_drop: source-side words in, consumer-side words out,
// plus the committed/dropped packet counters.
interface pkt_fifo_drop_if #(
    parameter int DW    = 16,
    parameter int CNT_W = 16
);
    logic [DW-1:0]    din;
    logic             din_vld;
    logic             din_sop;
    logic             din_eop;
    logic             din_err;
    logic [DW-1:0]    dout;
    logic             dout_vld;
    logic             dout_sop;
    logic             dout_eop;
    logic             dout_rdy;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] pkt_cnt;

    modport master (
        output din, din_vld, din_sop, din_eop, din_err, dout_rdy,
        input  dout, dout_vld, dout_sop, dout_eop, drop_cnt, pkt_cnt
    );

    modport slave (
        input  din, din_vld, din_sop, din_eop, din_err, dout_rdy,
        output dout, dout_vld, dout_sop, dout_eop, drop_cnt, pkt_cnt
    );
endinterface

// File: rtl/pkt_fifo_drop.sv
// Store-and-forward packet FIFO: packets become visible to the reader only once their eop
// word is accepted as good; bad, aborted or overflowing packets are rewound away.
module pkt_fifo_drop #(
    parameter int DW     = 16,
    parameter int AW     = 6,
    parameter int CHK_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pkt_fifo_drop_if.slave bus
);
    localparam int             DEPTH   = 2 ** AW;
    localparam logic [AW:0]    DEPTH_P = {1'b1, {AW{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} wr_state_t;

    wr_state_t        state_reg, state_next;
    logic [AW:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW:0]      cm_ptr_reg, cm_ptr_next;
    logic [AW:0]      rd_ptr_reg;
    logic [DW-1:0]    sum_reg, sum_next;
    logic [CNT_W-1:0] drop_cnt_reg, pkt_cnt_reg;
    logic [CNT_W:0]   drop_sum, pkt_sum;
    logic [1:0]       drop_inc;
    logic             pkt_inc;

    logic [DW+1:0]    mem [DEPTH];
    logic [DW+1:0]    ram_q;
    logic             rq_vld_reg;
    logic [DW-1:0]    dout_reg;
    logic             dout_vld_reg, dout_sop_reg, dout_eop_reg;

    logic             pkt_word, space_full, wr_en;
    logic [AW:0]      base_ptr;
    logic [DW-1:0]    sum_base, sum_new;
    logic             out_ready, rd_en;

    // A sop word always restarts at the commit point, so an open packet is implicitly rewound.
    always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg;
        cm_ptr_next = cm_ptr_reg;
        sum_next    = sum_reg;
        drop_inc    = 2'd0;
        pkt_inc     = 1'b0;
        wr_en       = 1'b0;
        pkt_word    = bus.din_vld && (bus.din_sop || state_reg == RECV);
        base_ptr    = bus.din_sop ? cm_ptr_reg : wr_ptr_reg;
        sum_base    = bus.din_sop ? '0 : sum_reg;
        sum_new     = sum_base + bus.din;
        space_full  = (base_ptr - rd_ptr_reg) == DEPTH_P;

        if (pkt_word) begin
            if (bus.din_sop && state_reg == RECV) begin
                drop_inc = 2'd1;
            end
            if (space_full) begin
                wr_ptr_next = cm_ptr_reg;
                drop_inc    = drop_inc + 2'd1;
                state_next  = bus.din_eop ? IDLE : DISCARD;
            end else begin
                wr_en = 1'b1;
                if (bus.din_eop) begin
                    state_next = IDLE;
                    if (!bus.din_err && (CHK_EN == 0 || sum_new == '0)) begin
                        wr_ptr_next = base_ptr + 1'b1;
                        cm_ptr_next = base_ptr + 1'b1;
                        pkt_inc     = 1'b1;
                    end else begin
                        wr_ptr_next = cm_ptr_reg;
                        drop_inc    = drop_inc + 2'd1;
                    end
                end else begin
                    wr_ptr_next = base_ptr + 1'b1;
                    sum_next    = sum_new;
                    state_next  = RECV;
                end
            end
        end else if (bus.din_vld && bus.din_eop && state_reg == DISCARD) begin
            state_next = IDLE;
        end
    end

    assign drop_sum = {1'b0, drop_cnt_reg} + (CNT_W + 1)'(drop_inc);
    assign pkt_sum  = {1'b0, pkt_cnt_reg} + (CNT_W + 1)'(pkt_inc);

    // Two-stage read: RAM output register acts as the skid slot behind the output register.
    assign out_ready = !dout_vld_reg || bus.dout_rdy;
    assign rd_en     = (cm_ptr_reg != rd_ptr_reg) && (!rq_vld_reg || out_ready);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[base_ptr[AW-1:0]] <= {bus.din_sop, bus.din_eop, bus.din};
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr_reg[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            cm_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            sum_reg      <= '0;
            drop_cnt_reg <= '0;
            pkt_cnt_reg  <= '0;
            rq_vld_reg   <= 1'b0;
            dout_reg     <= '0;
            dout_vld_reg <= 1'b0;
            dout_sop_reg <= 1'b0;
            dout_eop_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            cm_ptr_reg   <= cm_ptr_next;
            sum_reg      <= sum_next;
            drop_cnt_reg <= drop_sum[CNT_W] ? CNT_MAX : drop_sum[CNT_W-1:0];
            pkt_cnt_reg  <= pkt_sum[CNT_W] ? CNT_MAX : pkt_sum[CNT_W-1:0];

            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                rq_vld_reg <= 1'b1;
            end else if (out_ready) begin
                rq_vld_reg <= 1'b0;
            end

            if (out_ready) begin
                dout_vld_reg <= rq_vld_reg;
                if (rq_vld_reg) begin
                    {dout_sop_reg, dout_eop_reg, dout_reg} <= ram_q;
                end else begin
                    dout_sop_reg <= 1'b0;
                    dout_eop_reg <= 1'b0;
                end
            end
        end
    end

    assign bus.dout     = dout_reg;
    assign bus.dout_vld = dout_vld_reg;
    assign bus.dout_sop = dout_sop_reg;
    assign bus.dout_eop = dout_eop_reg;
    assign bus.drop_cnt = drop_cnt_reg;
    assign bus.pkt_cnt  = pkt_cnt_reg;
endmodule

// File: tb/tb_pkt_fifo_drop.sv
// Directed bench for pkt_fifo_drop: three instances (default, no checksum, 8-deep), one active
// at a time; forwarded words are scoreboarded and held outputs are checked during backpressure.
module tb_pkt_fifo_drop;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic        din_vld, din_sop, din_eop, din_err, dout_rdy;
    int          sel;
    bit          tog;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pkt_fifo_drop_if #(.DW(16), .CNT_W(16)) if0 ();
    pkt_fifo_drop_if #(.DW(16), .CNT_W(16)) if1 ();
    pkt_fifo_drop_if #(.DW(16), .CNT_W(16)) if2 ();

    pkt_fifo_drop #(.DW(16), .AW(6), .CHK_EN(1), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    pkt_fifo_drop #(.DW(16), .AW(6), .CHK_EN(0), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    pkt_fifo_drop #(.DW(16), .AW(3), .CHK_EN(1), .CNT_W(16)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.din = din;  assign if0.din_sop = din_sop;  assign if0.din_eop = din_eop;
    assign if1.din = din;  assign if1.din_sop = din_sop;  assign if1.din_eop = din_eop;
    assign if2.din = din;  assign if2.din_sop = din_sop;  assign if2.din_eop = din_eop;
    assign if0.din_err = din_err;  assign if0.dout_rdy = dout_rdy;
    assign if1.din_err = din_err;  assign if1.dout_rdy = dout_rdy;
    assign if2.din_err = din_err;  assign if2.dout_rdy = dout_rdy;
    assign if0.din_vld = din_vld && (sel == 0);
    assign if1.din_vld = din_vld && (sel == 1);
    assign if2.din_vld = din_vld && (sel == 2);

    logic [15:0] o_dout [3];
    logic        o_vld [3], o_sop [3], o_eop [3];
    logic [15:0] o_drop [3], o_pkt [3];
    assign o_dout[0] = if0.dout;  assign o_vld[0] = if0.dout_vld;  assign o_sop[0] = if0.dout_sop;
    assign o_dout[1] = if1.dout;  assign o_vld[1] = if1.dout_vld;  assign o_sop[1] = if1.dout_sop;
    assign o_dout[2] = if2.dout;  assign o_vld[2] = if2.dout_vld;  assign o_sop[2] = if2.dout_sop;
    assign o_eop[0]  = if0.dout_eop;  assign o_drop[0] = if0.drop_cnt;  assign o_pkt[0] = if0.pkt_cnt;
    assign o_eop[1]  = if1.dout_eop;  assign o_drop[1] = if1.drop_cnt;  assign o_pkt[1] = if1.pkt_cnt;
    assign o_eop[2]  = if2.dout_eop;  assign o_drop[2] = if2.drop_cnt;  assign o_pkt[2] = if2.pkt_cnt;

    // Scoreboard entry: {instance, sop, eop, data}
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;
    logic [17:0] held [3];
    bit          held_f [3];
    int          exp_drop [3];
    int          exp_pkt [3];
    logic [15:0] pkt [16];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) held_f[k] = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (held_f[k]) begin
                    n_cmp++;
                    assert ({o_vld[k], o_sop[k], o_eop[k], o_dout[k]} === {1'b1, held[k]}) else begin
                        n_err++;
                        $error("FAIL hold dut%0d got %h want %h", k,
                               {o_vld[k], o_sop[k], o_eop[k], o_dout[k]}, {1'b1, held[k]});
                    end
                end
                held_f[k] = o_vld[k] && !dout_rdy;
                held[k]   = {o_sop[k], o_eop[k], o_dout[k]};
                if (o_vld[k] && dout_rdy) begin
                    $display("out dut%0d data %h sop %0d eop %0d", k, o_dout[k], o_sop[k], o_eop[k]);
                    n_cmp++;
                    assert (exp_q.size() > 0) else begin
                        n_err++;
                        $error("FAIL unexpected_word dut%0d got %h want none", k, o_dout[k]);
                    end
                    if (exp_q.size() > 0) begin
                        mon_e = exp_q.pop_front();
                        n_cmp++;
                        assert ({2'(k), o_sop[k], o_eop[k], o_dout[k]} === mon_e) else begin
                            n_err++;
                            $error("FAIL out_word got %h want %h",
                                   {2'(k), o_sop[k], o_eop[k], o_dout[k]}, mon_e);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic chk_cnt(input int k);
        chk($sformatf("drop_cnt%0d", k), 32'(o_drop[k]), 32'(exp_drop[k]));
        chk($sformatf("pkt_cnt%0d", k), 32'(o_pkt[k]), 32'(exp_pkt[k]));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (tog) dout_rdy = ~dout_rdy;
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        din_err = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input logic s, input logic e, input logic er);
        din = d; din_vld = 1'b1; din_sop = s; din_eop = e; din_err = er;
        $display("in  dut%0d data %h sop %0d eop %0d err %0d", sel, d, s, e, er);
        cyc();
    endtask

    task automatic make_pkt(input int len, input bit good);
        logic [15:0] s = '0;
        for (int i = 0; i < len - 1; i++) begin
            pkt[i] = 16'($urandom);
            s = s + pkt[i];
        end
        pkt[len-1] = good ? 16'(-s) : 16'(-s + 16'd1);
    endtask

    task automatic send_pkt(input int len, input logic er, input bit fwd);
        for (int i = 0; i < len; i++) begin
            if (fwd) exp_q.push_back({2'(sel), (i == 0), (i == len - 1), pkt[i]});
            send_word(pkt[i], i == 0, i == len - 1, er && (i == len - 1));
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) cyc();
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        cyc();
        cyc();
        chk("idle_vld", {29'd0, o_vld[0], o_vld[1], o_vld[2]}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; din = '0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_err = 1'b0;
        dout_rdy = 1'b1; sel = 0; tog = 1'b0;
        for (int k = 0; k < 3; k++) begin exp_drop[k] = 0; exp_pkt[k] = 0; end
        cyc(); cyc();
        chk("rst_outputs", {12'd0, o_vld[0], o_sop[0], o_eop[0], 1'b0, o_dout[0]}, 32'd0);
        chk_cnt(0);
        rst_n = 1'b1;
        cyc();

        // 1: good 4-word packet, latency 2 edges after eop
        pkt[0] = 16'h0001; pkt[1] = 16'h0002; pkt[2] = 16'h0003; pkt[3] = 16'hFFFA;
        send_pkt(4, 1'b0, 1'b1);
        chk("lat_n0", {31'd0, o_vld[0]}, 32'd0);
        cyc();
        chk("lat_n1", {31'd0, o_vld[0]}, 32'd0);
        cyc();
        chk("lat_n2", {15'd0, o_vld[0], o_dout[0]}, {15'd0, 1'b1, 16'h0001});
        wait_drain();
        exp_pkt[0] = 1; chk_cnt(0);

        // 2: bad checksum dropped, then a good packet passes
        pkt[3] = 16'hFFFB;
        send_pkt(4, 1'b0, 1'b0);
        wait_drain();
        exp_drop[0] = 1; chk_cnt(0);
        make_pkt(5, 1'b1);
        send_pkt(5, 1'b0, 1'b1);
        wait_drain();
        exp_pkt[0] = 2; chk_cnt(0);

        // 3: din_err drops a good-sum packet; without checksum a bad sum is forwarded
        make_pkt(3, 1'b1);
        send_pkt(3, 1'b1, 1'b0);
        wait_drain();
        exp_drop[0] = 2; chk_cnt(0);
        sel = 1;
        make_pkt(4, 1'b0);
        send_pkt(4, 1'b0, 1'b1);
        wait_drain();
        make_pkt(2, 1'b1);
        send_pkt(2, 1'b1, 1'b0);
        wait_drain();
        exp_pkt[1] = 1; exp_drop[1] = 1; chk_cnt(1);

        // 4: 8-deep instance, 10-word packet overflows on word 9
        sel = 2;
        make_pkt(10, 1'b1);
        for (int i = 0; i < 10; i++) begin
            send_word(pkt[i], i == 0, i == 9, 1'b0);
            if (i == 7) chk("ovf_before", 32'(o_drop[2]), 32'd0);
            if (i == 8) chk("ovf_at9", 32'(o_drop[2]), 32'd1);
        end
        wait_drain();
        exp_drop[2] = 1; chk_cnt(2);
        make_pkt(8, 1'b1);
        send_pkt(8, 1'b0, 1'b1);
        wait_drain();
        exp_pkt[2] = 1; chk_cnt(2);

        // 5: sop inside an open packet aborts it
        sel = 0;
        make_pkt(3, 1'b1);
        for (int i = 0; i < 3; i++) send_word(pkt[i], i == 0, 1'b0, 1'b0);
        make_pkt(4, 1'b1);
        send_pkt(4, 1'b0, 1'b1);
        wait_drain();
        exp_drop[0] = 3; exp_pkt[0] = 3; chk_cnt(0);

        // 6: back-to-back packets under toggling ready, then reset mid-stream
        tog = 1'b1;
        make_pkt(5, 1'b1); send_pkt(5, 1'b0, 1'b1);
        make_pkt(3, 1'b1); send_pkt(3, 1'b0, 1'b1);
        make_pkt(6, 1'b1); send_pkt(6, 1'b0, 1'b1);
        wait_drain();
        exp_pkt[0] = 6; chk_cnt(0);
        make_pkt(6, 1'b1); send_pkt(6, 1'b0, 1'b1);
        make_pkt(5, 1'b1);
        for (int i = 0; i < 3; i++) send_word(pkt[i], i == 0, 1'b0, 1'b0);
        chk("vld_before_rst", {31'd0, o_vld[0]}, 32'd1);
        tog = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        cyc();
        chk("rst_mid_outputs", {12'd0, o_vld[0], o_sop[0], o_eop[0], 1'b0, o_dout[0]}, 32'd0);
        exp_drop[0] = 0; exp_pkt[0] = 0; chk_cnt(0);
        dout_rdy = 1'b1;
        rst_n = 1'b1;
        cyc();
        make_pkt(4, 1'b1);
        send_pkt(4, 1'b0, 1'b1);
        wait_drain();
        exp_pkt[0] = 1; chk_cnt(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
